rs_alu: RTL and testbench
=========================

Name: rs_alu

Overview:
- Reservation station that feeds the integer ALU. It is the issuing end of the ALU's cal/done interface.
- Holds up to 2^RS_WIDTH dispatched ALU ops and captures pending operands by snooping ALU and LSB result broadcasts.
- Each cycle it issues the oldest-indexed ready entry to the ALU as a one-cycle registered cal_signal pulse.
- Sits between the dispatcher, the ALU, the LSB broadcast and the ROB flush line.

Parameters:
ROB_WIDTH  4  width of ROB tags used for destinations and operand dependencies
RS_WIDTH   3  log2 of entry count (8 entries)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; all state holds when low
clear_signal  input  1  misprediction flush
issue_valid  input  1  dispatcher writes one entry this cycle
issue_opcode  input  4  ALU opcode: AND=1 OR=2 XOR=3 ADD=4 SUB=5 SRL=6 SRA=7 SLL=8 LT=9 LTU=10 EQ=11 NE=12 GE=13 GEU=14 JALR=15
issue_lhs_ready  input  1  lhs value valid
issue_lhs_value  input  32  lhs value
issue_lhs_tag  input  ROB_WIDTH  producer tag when lhs is not ready
issue_rhs_ready, issue_rhs_value, issue_rhs_tag  input  1/32/ROB_WIDTH  same fields for rhs
issue_tag  input  ROB_WIDTH  destination ROB tag
rs_full  output  1  combinational; high when every entry is busy
alu_done  input  1  ALU broadcast valid
alu_value  input  32  ALU broadcast value
alu_tag  input  ROB_WIDTH  ALU broadcast tag
lsb_done, lsb_value, lsb_tag  input  1/32/ROB_WIDTH  LSB broadcast
cal_signal  output  1  registered; one-cycle issue pulse to the ALU
opcode  output  4  registered; opcode of the issued entry
lhs  output  32  registered; lhs operand
rhs  output  32  registered; rhs operand
tag  output  ROB_WIDTH  registered; destination tag

Behaviour:
- Clock and reset are fixed: one clock clk_in; rst_in is synchronous, active-high.
- Priority at each posedge: rst_in > (rdy_in & clear_signal) > normal operation. When rdy_in is low, nothing changes (entries and all outputs hold).
- Reset: all busy bits = 0; cal_signal = 0; opcode, lhs, rhs, tag = 0.
- Clear: all busy bits = 0 and cal_signal <= 0. Any issue and any snoop in that cycle are discarded.
- Entry fields: busy, opcode, lhs_rdy/lhs_val/lhs_q, rhs_rdy/rhs_val/rhs_q, dest.
- Allocation:
  - When issue_valid && !rs_full, the lowest-index free entry (free at cycle start) is written.
  - issue_valid while rs_full is ignored; nothing is written.
  - An entry freed by this cycle's select cannot be reallocated until the next cycle.
- Issue-time forwarding: a not-ready operand whose tag matches alu_tag (alu_done) or lsb_tag (lsb_done) in the same cycle is stored as ready with the broadcast value.
- Wakeup: every busy entry compares each not-ready operand tag against both broadcasts and captures value + ready on a match. If both broadcasts carry the same tag, the ALU value wins.
- Select:
  - Uses state at cycle start, so same-cycle wakeups are not eligible.
  - Picks the lowest-index busy entry with both operands ready.
  - If one is found: cal_signal <= 1; opcode/lhs/rhs/tag <= that entry; busy <= 0.
  - If none: cal_signal <= 0 and the other outputs hold.
- Latency:
  - Issue with both operands ready at edge N → cal_signal high after edge N+1 → ALU done after edge N+2.
  - A dependent woken by a broadcast at edge M issues after edge M+1.
- Throughput: at most one allocation and one issue per cycle; these may target different entries in the same cycle.
- rs_full is derived only from the registered busy vector. It has no combinational path from issue_valid or the broadcasts.

Test Plan:
- Reset, then issue ADD lhs=5 rhs=7 tag=3, both ready → next cycle cal_signal=1, opcode=4, lhs=5, rhs=7, tag=3; the following cycle cal_signal=0; rs_full=0 throughout.
- Issue SUB tag=2 with lhs waiting on tag 6; two cycles later alu_done=1, alu_tag=6, alu_value=20 → cal_signal exactly one cycle after the broadcast, lhs=20.
- Issue with rhs_tag=5 in the same cycle as lsb_done=1, lsb_tag=5, lsb_value=0xFFFF_FFFF → entry is stored ready; issued next cycle with rhs=0xFFFF_FFFF.
- Fill 8 entries, all waiting on tag 9 → rs_full=1 and a 9th issue_valid is ignored; broadcast tag 9 → entries 0..7 issue in index order on 8 consecutive cycles, and rs_full drops after the first issue.
- 4 busy entries, assert clear_signal with issue_valid and alu_done in the same cycle → next cycle all entries free, cal_signal=0, no later issue.
- Hold rdy_in=0 for 3 cycles with a ready entry pending → no cal_signal and no state change; issue occurs in the first cycle after rdy_in returns high.

Source files
------------

// File: rtl/rs_alu_if.sv
// Bundles the dispatcher, broadcast and ALU-issue signals of the ALU reservation station.
// The master side drives dispatch and broadcasts. The slave side (the RS) drives rs_full and the issue outputs.
// No storage or timing lives here; this is wiring only.
interface rs_alu_if #(
   parameter int ROB_WIDTH = 4
);
   // dispatcher write port
   logic                 issue_valid;
   logic [3:0]           issue_opcode;
   logic                 issue_lhs_ready;
   logic [31:0]          issue_lhs_value;
   logic [ROB_WIDTH-1:0] issue_lhs_tag;
   logic                 issue_rhs_ready;
   logic [31:0]          issue_rhs_value;
   logic [ROB_WIDTH-1:0] issue_rhs_tag;
   logic [ROB_WIDTH-1:0] issue_tag;
   logic                 rs_full;
   // result broadcasts
   logic                 alu_done;
   logic [31:0]          alu_value;
   logic [ROB_WIDTH-1:0] alu_tag;
   logic                 lsb_done;
   logic [31:0]          lsb_value;
   logic [ROB_WIDTH-1:0] lsb_tag;
   // issue to the ALU
   logic                 cal_signal;
   logic [3:0]           opcode;
   logic [31:0]          lhs;
   logic [31:0]          rhs;
   logic [ROB_WIDTH-1:0] tag;

   modport master (
      output issue_valid, issue_opcode, issue_lhs_ready, issue_lhs_value, issue_lhs_tag,
             issue_rhs_ready, issue_rhs_value, issue_rhs_tag, issue_tag,
             alu_done, alu_value, alu_tag, lsb_done, lsb_value, lsb_tag,
      input  rs_full, cal_signal, opcode, lhs, rhs, tag
   );

   modport slave (
      input  issue_valid, issue_opcode, issue_lhs_ready, issue_lhs_value, issue_lhs_tag,
             issue_rhs_ready, issue_rhs_value, issue_rhs_tag, issue_tag,
             alu_done, alu_value, alu_tag, lsb_done, lsb_value, lsb_tag,
      output rs_full, cal_signal, opcode, lhs, rhs, tag
   );
endinterface

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops and snoops ALU/LSB broadcasts for operands.
// It issues the lowest-index ready entry. An op that is ready on dispatch at edge N pulses cal_signal after edge N+1.
// Dispatch is refused through rs_full, which comes from registered busy bits only. rdy_in low freezes everything.
module rs_alu #(
   parameter int ROB_WIDTH = 4,
   parameter int RS_WIDTH  = 3
) (
   input  logic    clk_in,
   input  logic    rst_in,
   input  logic    rdy_in,
   input  logic    clear_signal,
   rs_alu_if.slave bus
);
   localparam int N = 1 << RS_WIDTH;

   typedef struct packed {
      logic                 busy;
      logic [3:0]           opcode;
      logic                 lhs_rdy;
      logic [31:0]          lhs_val;
      logic [ROB_WIDTH-1:0] lhs_q;
      logic                 rhs_rdy;
      logic [31:0]          rhs_val;
      logic [ROB_WIDTH-1:0] rhs_q;
      logic [ROB_WIDTH-1:0] dest;
   } entry_t;

   entry_t               ent_q [N];
   entry_t               ent_d [N];
   logic                 cal_q, cal_d;
   logic [3:0]           op_q, op_d;
   logic [31:0]          lhs_q, lhs_d;
   logic [31:0]          rhs_q, rhs_d;
   logic [ROB_WIDTH-1:0] tag_q, tag_d;

   logic [N-1:0]         busy_vec;
   logic                 full;
   logic                 sel_found;
   logic [RS_WIDTH-1:0]  sel_idx;
   logic [RS_WIDTH-1:0]  free_idx;

   // Resolve one operand against both broadcasts. The ALU result takes precedence on a tag tie.
   function automatic logic [32:0] snoop(
      input logic                 rdy,
      input logic [31:0]          val,
      input logic [ROB_WIDTH-1:0] q,
      input logic                 a_done,
      input logic [31:0]          a_val,
      input logic [ROB_WIDTH-1:0] a_tag,
      input logic                 l_done,
      input logic [31:0]          l_val,
      input logic [ROB_WIDTH-1:0] l_tag
   );
      logic [32:0] r;
      r = {rdy, val};
      if (!rdy) begin
         if (a_done && a_tag == q)      r = {1'b1, a_val};
         else if (l_done && l_tag == q) r = {1'b1, l_val};
      end
      return r;
   endfunction

   // Find the lowest busy+ready entry and the lowest free entry, using cycle-start state only.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      free_idx  = '0;
      busy_vec  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         busy_vec[i] = ent_q[i].busy;
         if (ent_q[i].busy && ent_q[i].lhs_rdy && ent_q[i].rhs_rdy) begin
            sel_found = 1'b1;
            sel_idx   = RS_WIDTH'(i);
         end
         if (!ent_q[i].busy) free_idx = RS_WIDTH'(i);
      end
      full = &busy_vec;
   end

   // Next entry state: wakeup, free the selected slot, allocate, then flush overrides all.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].busy) begin
            {ent_d[i].lhs_rdy, ent_d[i].lhs_val} = snoop(ent_q[i].lhs_rdy, ent_q[i].lhs_val, ent_q[i].lhs_q,
               bus.alu_done, bus.alu_value, bus.alu_tag, bus.lsb_done, bus.lsb_value, bus.lsb_tag);
            {ent_d[i].rhs_rdy, ent_d[i].rhs_val} = snoop(ent_q[i].rhs_rdy, ent_q[i].rhs_val, ent_q[i].rhs_q,
               bus.alu_done, bus.alu_value, bus.alu_tag, bus.lsb_done, bus.lsb_value, bus.lsb_tag);
         end
         if (sel_found && sel_idx == RS_WIDTH'(i)) ent_d[i].busy = 1'b0;
      end
      // the free slot was free at cycle start, so it never collides with the selected one
      if (bus.issue_valid && !full) begin
         ent_d[free_idx].busy   = 1'b1;
         ent_d[free_idx].opcode = bus.issue_opcode;
         ent_d[free_idx].lhs_q  = bus.issue_lhs_tag;
         ent_d[free_idx].rhs_q  = bus.issue_rhs_tag;
         ent_d[free_idx].dest   = bus.issue_tag;
         {ent_d[free_idx].lhs_rdy, ent_d[free_idx].lhs_val} = snoop(bus.issue_lhs_ready, bus.issue_lhs_value,
            bus.issue_lhs_tag, bus.alu_done, bus.alu_value, bus.alu_tag, bus.lsb_done, bus.lsb_value, bus.lsb_tag);
         {ent_d[free_idx].rhs_rdy, ent_d[free_idx].rhs_val} = snoop(bus.issue_rhs_ready, bus.issue_rhs_value,
            bus.issue_rhs_tag, bus.alu_done, bus.alu_value, bus.alu_tag, bus.lsb_done, bus.lsb_value, bus.lsb_tag);
      end
      if (clear_signal) begin
         for (int i = 0; i < N; i++) ent_d[i].busy = 1'b0;
      end
   end

   // Issue outputs: pulse cal for one cycle on a select; operand outputs hold otherwise.
   always_comb begin
      cal_d = 1'b0;
      op_d  = op_q;
      lhs_d = lhs_q;
      rhs_d = rhs_q;
      tag_d = tag_q;
      if (sel_found && !clear_signal) begin
         cal_d = 1'b1;
         op_d  = ent_q[sel_idx].opcode;
         lhs_d = ent_q[sel_idx].lhs_val;
         rhs_d = ent_q[sel_idx].rhs_val;
         tag_d = ent_q[sel_idx].dest;
      end
   end

   // State register: synchronous reset, frozen while rdy_in is low.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < N; i++) ent_q[i] <= '0;
         cal_q <= 1'b0;
         op_q  <= '0;
         lhs_q <= '0;
         rhs_q <= '0;
         tag_q <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
         cal_q <= cal_d;
         op_q  <= op_d;
         lhs_q <= lhs_d;
         rhs_q <= rhs_d;
         tag_q <= tag_d;
      end
   end

   assign bus.rs_full    = full;
   assign bus.cal_signal = cal_q;
   assign bus.opcode     = op_q;
   assign bus.lhs        = lhs_q;
   assign bus.rhs        = rhs_q;
   assign bus.tag        = tag_q;
endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu. Expected issue packets are queued when stimulus is driven.
// A negedge monitor pops one packet for every cal_signal pulse and compares it.
// The stimulus thread also checks pulse timing and rs_full at fixed cycles.
module tb_rs_alu;
   logic clk_in = 1'b0;
   logic rst_in, rdy_in, clear_signal;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [71:0] sb [$];

   rs_alu_if #(.ROB_WIDTH(4)) bus ();

   rs_alu #(.ROB_WIDTH(4), .RS_WIDTH(3)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .clear_signal (clear_signal),
      .bus          (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every issue pulse must match the oldest queued expectation
   always @(negedge clk_in) begin
      if (!rst_in && bus.cal_signal === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_issue: got op=%h lhs=%h rhs=%h tag=%h with nothing expected",
                     bus.opcode, bus.lhs, bus.rhs, bus.tag);
         end else begin
            check("issue_pkt", {4'h0, bus.opcode, bus.lhs, bus.rhs, bus.tag}, {4'h0, sb.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid = 0; bus.issue_opcode = 0;
      bus.issue_lhs_ready = 0; bus.issue_lhs_value = 0; bus.issue_lhs_tag = 0;
      bus.issue_rhs_ready = 0; bus.issue_rhs_value = 0; bus.issue_rhs_tag = 0;
      bus.issue_tag = 0;
      bus.alu_done = 0; bus.alu_value = 0; bus.alu_tag = 0;
      bus.lsb_done = 0; bus.lsb_value = 0; bus.lsb_tag = 0;
      clear_signal = 0;
   endtask

   task automatic issue(input logic [3:0] op, input logic lr, input logic [31:0] lv, input logic [3:0] lq,
                        input logic rr, input logic [31:0] rv, input logic [3:0] rq, input logic [3:0] dest);
      bus.issue_valid = 1; bus.issue_opcode = op;
      bus.issue_lhs_ready = lr; bus.issue_lhs_value = lv; bus.issue_lhs_tag = lq;
      bus.issue_rhs_ready = rr; bus.issue_rhs_value = rv; bus.issue_rhs_tag = rq;
      bus.issue_tag = dest;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rdy_in = 1;
      rst_in = 1;
      repeat (3) step();
      rst_in = 0;
      step();
      // reset state
      check("rst_cal", 72'(bus.cal_signal), 72'd0);
      check("rst_full", 72'(bus.rs_full), 72'd0);
      check("rst_outs", {bus.opcode, bus.lhs, bus.rhs, bus.tag}, 72'd0);

      // ADD 5+7 -> tag 3, both ready
      issue(4'd4, 1, 32'd5, 0, 1, 32'd7, 0, 4'd3);
      sb.push_back({4'd4, 32'd5, 32'd7, 4'd3});
      step(); idle();
      check("add_no_early", 72'(bus.cal_signal), 72'd0);
      step();
      check("add_cal", 72'(bus.cal_signal), 72'd1);
      check("add_full", 72'(bus.rs_full), 72'd0);
      step();
      check("add_pulse_end", 72'(bus.cal_signal), 72'd0);

      // SUB with lhs waiting on tag 6, woken by the ALU broadcast
      issue(4'd5, 0, 32'd0, 4'd6, 1, 32'd3, 0, 4'd2);
      step(); idle();
      step();
      check("sub_wait", 72'(bus.cal_signal), 72'd0);
      bus.alu_done = 1; bus.alu_tag = 4'd6; bus.alu_value = 32'd20;
      sb.push_back({4'd5, 32'd20, 32'd3, 4'd2});
      step(); idle();
      check("sub_not_same_cycle", 72'(bus.cal_signal), 72'd0);
      step();
      check("sub_cal", 72'(bus.cal_signal), 72'd1);
      step();

      // issue-time forwarding from the LSB broadcast
      issue(4'd3, 1, 32'd1, 0, 0, 32'd0, 4'd5, 4'd7);
      bus.lsb_done = 1; bus.lsb_tag = 4'd5; bus.lsb_value = 32'hFFFF_FFFF;
      sb.push_back({4'd3, 32'd1, 32'hFFFF_FFFF, 4'd7});
      step(); idle();
      check("fwd_no_early", 72'(bus.cal_signal), 72'd0);
      step();
      check("fwd_cal", 72'(bus.cal_signal), 72'd1);
      step();

      // fill all 8 entries waiting on tag 9
      for (int i = 0; i < 8; i++) begin
         issue(4'd4, 0, 32'd0, 4'd9, 1, 32'(i), 0, 4'(i));
         step();
      end
      idle();
      check("fill_full", 72'(bus.rs_full), 72'd1);
      issue(4'd4, 1, 32'd1, 0, 1, 32'd1, 0, 4'd15);
      step(); idle();
      check("ninth_full", 72'(bus.rs_full), 72'd1);
      check("ninth_no_cal", 72'(bus.cal_signal), 72'd0);
      bus.alu_done = 1; bus.alu_tag = 4'd9; bus.alu_value = 32'd100;
      for (int i = 0; i < 8; i++) sb.push_back({4'd4, 32'd100, 32'(i), 4'(i)});
      step(); idle();
      check("wake_no_cal", 72'(bus.cal_signal), 72'd0);
      check("wake_still_full", 72'(bus.rs_full), 72'd1);
      step();
      check("drain0_cal", 72'(bus.cal_signal), 72'd1);
      check("drain0_full_drop", 72'(bus.rs_full), 72'd0);
      for (int k = 1; k < 8; k++) begin
         step();
         check("drain_cal", 72'(bus.cal_signal), 72'd1);
         check("drain_tag", 72'(bus.tag), 72'(k));
      end
      step();
      check("drain_done", 72'(bus.cal_signal), 72'd0);

      // flush with a concurrent issue and a matching broadcast
      for (int i = 0; i < 4; i++) begin
         issue(4'd2, 0, 32'd0, 4'd10, 1, 32'(i), 0, 4'(i));
         step();
      end
      idle();
      check("pre_clear_full", 72'(bus.rs_full), 72'd0);
      clear_signal = 1;
      issue(4'd4, 1, 32'd1, 0, 1, 32'd1, 0, 4'd12);
      bus.alu_done = 1; bus.alu_tag = 4'd10; bus.alu_value = 32'd1;
      step(); idle();
      check("clear_cal", 72'(bus.cal_signal), 72'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("clear_quiet", 72'(bus.cal_signal), 72'd0);
      end
      bus.alu_done = 1; bus.alu_tag = 4'd10; bus.alu_value = 32'd1;
      step(); idle();
      step(); step();
      check("clear_no_late", 72'(bus.cal_signal), 72'd0);

      // rdy_in low freezes a pending ready entry
      issue(4'd1, 1, 32'hF0, 0, 1, 32'h3C, 0, 4'd4);
      sb.push_back({4'd1, 32'hF0, 32'h3C, 4'd4});
      step(); idle();
      rdy_in = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_no_cal", 72'(bus.cal_signal), 72'd0);
      end
      rdy_in = 1;
      step();
      check("stall_resume_cal", 72'(bus.cal_signal), 72'd1);
      check("stall_resume_tag", 72'(bus.tag), 72'd4);
      step();
      check("stall_pulse_end", 72'(bus.cal_signal), 72'd0);

      // both broadcasts carry the same tag: ALU value wins
      issue(4'd4, 0, 32'd0, 4'd11, 1, 32'd1, 0, 4'd9);
      step(); idle();
      bus.alu_done = 1; bus.alu_tag = 4'd11; bus.alu_value = 32'h11;
      bus.lsb_done = 1; bus.lsb_tag = 4'd11; bus.lsb_value = 32'h22;
      sb.push_back({4'd4, 32'h11, 32'd1, 4'd9});
      step(); idle();
      step();
      check("tie_cal", 72'(bus.cal_signal), 72'd1);
      step(); step();

      check("scoreboard_empty", 72'(sb.size()), 72'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
